// File: rtl/med3x3_filter_unit.sv
// Streaming 3x3 median filter: sliding window of pre-sorted columns feeding a two-stage median network.
// Optional macro MED_PASSTHRU_EN adds a bypass input that selects the window centre pixel instead.
module med3x3_filter_unit #(
    parameter int BIT_LENGTH = 5,
    parameter int IMG_DIM    = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  row_start,
    input  logic [BIT_LENGTH-1:0] pixel_in0,
    input  logic [BIT_LENGTH-1:0] pixel_in1,
    input  logic [BIT_LENGTH-1:0] pixel_in2,
    output logic                  out_valid,
    output logic [BIT_LENGTH-1:0] median_out,
    output logic                  out_last
`ifdef MED_PASSTHRU_EN
    ,
    input  logic                  bypass
`endif
);

    localparam int IW = (IMG_DIM > 2) ? $clog2(IMG_DIM) : 2;
    localparam logic [IW-1:0] LAST_COL = IW'(IMG_DIM - 1);
    localparam logic [IW-1:0] FULL_COL = IW'(2);

    typedef logic [BIT_LENGTH-1:0] pix_t;
    typedef enum logic {S_IDLE, S_RUN} state_t;

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    state_t        state_q, state_d;
    logic [IW-1:0] col_idx_q, col_idx_d;
    logic          accept;
    logic          win_valid_d, win_last_d;
    logic          win_valid_q, win_last_q;
    pix_t          s_lo, s_md, s_hi;
    pix_t          lo_q [0:2];
    pix_t          md_q [0:2];
    pix_t          hi_q [0:2];

    pix_t          a_lo_d, a_md_d, a_hi_d;
    pix_t          a_lo_q, a_md_q, a_hi_q;
    logic          a_valid_q, a_last_q;

    pix_t          result_d;
    pix_t          median_q;
    logic          valid_q, last_q;

`ifdef MED_PASSTHRU_EN
    pix_t          ctr1_q, ctr2_q, a_ctr_q;
    logic          win_byp_q, a_byp_q;
`endif

    // Until a row_start is seen, columns are ignored so no window forms from reset-cleared data.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        accept      = 1'b0;
        if (in_valid) begin
            if (row_start) begin
                accept    = 1'b1;
                col_idx_d = '0;
                state_d   = S_RUN;
            end else if (state_q == S_RUN && col_idx_q != LAST_COL) begin
                accept    = 1'b1;
                col_idx_d = col_idx_q + 1'b1;
            end
        end
        win_valid_d = accept && (col_idx_d >= FULL_COL);
        win_last_d  = accept && (col_idx_d == LAST_COL);
    end

    always_comb begin
        s_lo   = min2(min2(pixel_in0, pixel_in1), pixel_in2);
        s_hi   = max2(max2(pixel_in0, pixel_in1), pixel_in2);
        s_md   = med3(pixel_in0, pixel_in1, pixel_in2);
        a_lo_d = max2(max2(lo_q[0], lo_q[1]), lo_q[2]);
        a_md_d = med3(md_q[0], md_q[1], md_q[2]);
        a_hi_d = min2(min2(hi_q[0], hi_q[1]), hi_q[2]);
`ifdef MED_PASSTHRU_EN
        result_d = a_byp_q ? a_ctr_q : med3(a_lo_q, a_md_q, a_hi_q);
`else
        result_d = med3(a_lo_q, a_md_q, a_hi_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            col_idx_q   <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            lo_q        <= '{default: '0};
            md_q        <= '{default: '0};
            hi_q        <= '{default: '0};
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            if (accept) begin
                lo_q[0] <= lo_q[1];
                lo_q[1] <= lo_q[2];
                lo_q[2] <= s_lo;
                md_q[0] <= md_q[1];
                md_q[1] <= md_q[2];
                md_q[2] <= s_md;
                hi_q[0] <= hi_q[1];
                hi_q[1] <= hi_q[2];
                hi_q[2] <= s_hi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_q <= 1'b0;
            a_last_q  <= 1'b0;
            a_lo_q    <= '0;
            a_md_q    <= '0;
            a_hi_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            median_q  <= '0;
        end else begin
            a_valid_q <= win_valid_q;
            a_last_q  <= win_valid_q & win_last_q;
            if (win_valid_q) begin
                a_lo_q <= a_lo_d;
                a_md_q <= a_md_d;
                a_hi_q <= a_hi_d;
            end
            valid_q <= a_valid_q;
            last_q  <= a_valid_q & a_last_q;
            if (a_valid_q) begin
                median_q <= result_d;
            end
        end
    end

`ifdef MED_PASSTHRU_EN
    // Raw (unsorted) middle pixels track the window so the centre is available for passthrough.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctr1_q    <= '0;
            ctr2_q    <= '0;
            win_byp_q <= 1'b0;
            a_ctr_q   <= '0;
            a_byp_q   <= 1'b0;
        end else begin
            win_byp_q <= accept & bypass;
            if (accept) begin
                ctr1_q <= ctr2_q;
                ctr2_q <= pixel_in1;
            end
            if (win_valid_q) begin
                a_ctr_q <= ctr1_q;
                a_byp_q <= win_byp_q;
            end
        end
    end
`endif

    assign out_valid  = valid_q;
    assign out_last   = last_q;
    assign median_out = median_q;

endmodule

// File: tb/tb_med3x3_filter_unit.sv
// Scoreboard bench for med3x3_filter_unit: a reference window model pushes expected results with due cycle.
module tb_med3x3_filter_unit;

    localparam int BW  = 5;
    localparam int DIM = 20;

    logic          clk = 1'b0;
    logic          reset, in_valid, row_start;
    logic [BW-1:0] p0, p1, p2;
    logic          out_valid, out_last;
    logic [BW-1:0] median_out;
`ifdef MED_PASSTHRU_EN
    logic          bypass;
`endif

    med3x3_filter_unit #(.BIT_LENGTH(BW), .IMG_DIM(DIM)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .row_start  (row_start),
        .pixel_in0  (p0),
        .pixel_in1  (p1),
        .pixel_in2  (p2),
        .out_valid  (out_valid),
        .median_out (median_out),
        .out_last   (out_last)
`ifdef MED_PASSTHRU_EN
        ,
        .bypass     (bypass)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int med;
        int last;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_pulse = 0;
    int   n_last = 0;
    int   last_med = 0;

    int   m_win [0:2][0:2];
    int   m_idx;
    bit   m_armed;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int median9();
        int v [0:8];
        int t;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[i*3+j] = m_win[i][j];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return v[4];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs sampled 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset) begin
            sb.delete();
            last_med = 0;
            check("rst_valid", int'(out_valid), 0);
            check("rst_med", int'(median_out), 0);
            check("rst_last", int'(out_last), 0);
        end else if (out_valid) begin
            n_pulse++;
            if (out_last) n_last++;
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("median", int'(median_out), e.med);
                check("last", int'(out_last), e.last);
                check("latency", cyc, e.due);
                last_med = e.med;
            end
        end else begin
            check("hold_med", int'(median_out), last_med);
            check("idle_last", int'(out_last), 0);
            if (sb.size() > 0 && sb[0].due < cyc) begin
                check("missing_valid", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic model_col(input int a, input int b, input int c, input bit rs, input bit byp);
        exp_t e;
        if (!(rs || (m_armed && m_idx != DIM - 1))) return;
        if (rs) begin
            m_idx   = 0;
            m_armed = 1'b1;
        end else begin
            m_idx++;
        end
        for (int j = 0; j < 3; j++) begin
            m_win[0][j] = m_win[1][j];
            m_win[1][j] = m_win[2][j];
        end
        m_win[2][0] = a; m_win[2][1] = b; m_win[2][2] = c;
        if (m_idx >= 2) begin
            e.med  = byp ? m_win[1][1] : median9();
            e.last = (m_idx == DIM - 1) ? 1 : 0;
            e.due  = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic col(input int a, input int b, input int c, input bit rs, input bit byp = 1'b0);
        @(negedge clk);
        in_valid  = 1'b1;
        row_start = rs;
        p0 = BW'(a); p1 = BW'(b); p2 = BW'(c);
`ifdef MED_PASSTHRU_EN
        bypass = byp;
        model_col(a, b, c, rs, byp);
`else
        model_col(a, b, c, rs, 1'b0);
`endif
    endtask

    task automatic rcol(input bit rs);
        col(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), rs);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            row_start = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && sb.size() > 0; i++) @(negedge clk);
        idle(2);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        row_start = 1'b0;
        m_armed  = 1'b0;
        m_idx    = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m_win[i][j] = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int bp, bl;

    initial begin
        reset = 1'b1; in_valid = 1'b0; row_start = 1'b0;
        p0 = '0; p1 = '0; p2 = '0;
`ifdef MED_PASSTHRU_EN
        bypass = 1'b0;
`endif
        m_armed = 1'b0; m_idx = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m_win[i][j] = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Full sweep; first window gives 4
        bp = n_pulse; bl = n_last;
        col(1, 9, 5, 1); col(3, 7, 2, 0); col(31, 0, 4, 0);
        for (int i = 3; i < DIM; i++) rcol(1'b0);
        idle(1); drain();
        check("sweep_pulses", n_pulse - bp, 18);
        check("sweep_lasts", n_last - bl, 1);

        // Uniform window and extreme values
        col(17, 17, 17, 1); col(17, 17, 17, 0); col(17, 17, 17, 0);
        col(0, 0, 0, 1); col(31, 31, 31, 0); col(31, 0, 31, 0);
        idle(1); drain();

        // Two-cycle gaps between columns
        bp = n_pulse;
        col(1, 9, 5, 1); idle(2);
        col(3, 7, 2, 0); idle(2);
        for (int i = 0; i < 4; i++) begin rcol(1'b0); idle(2); end
        drain();
        check("gap_pulses", n_pulse - bp, 4);

        // Restart at column 10, then a full sweep plus one overrun column
        bp = n_pulse; bl = n_last;
        for (int i = 0; i < 10; i++) rcol(i == 0);
        rcol(1'b1);
        for (int i = 1; i < DIM; i++) rcol(1'b0);
        rcol(1'b0);
        idle(1); drain();
        check("restart_pulses", n_pulse - bp, 26);
        check("restart_lasts", n_last - bl, 1);

        // Reset one cycle after a completing column kills the in-flight result
        bp = n_pulse;
        col(1, 9, 5, 1); col(3, 7, 2, 0); col(31, 0, 4, 0);
        do_reset();
        idle(6);
        check("reset_pulses", n_pulse - bp, 0);
        check("reset_med", int'(median_out), 0);

        // After reset, columns without row_start are ignored
        col(5, 6, 7, 0); col(8, 9, 10, 0); col(11, 12, 13, 0);
        idle(6); drain();
        check("unarmed_pulses", n_pulse - bp, 0);

`ifdef MED_PASSTHRU_EN
        bp = n_pulse;
        col(1, 9, 5, 1); col(3, 7, 2, 0); col(31, 0, 4, 0, 1'b1);
        idle(1); drain();
        check("bypass_pulses", n_pulse - bp, 1);
        check("bypass_value", int'(median_out), 7);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
